// File: rtl/uart_tx_arb_if.sv
// Bus between the uart_tx_arb arbiter, its byte requesters and the shared uart_tx.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface uart_tx_arb_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic [2:0]        grant_id;
   logic              arb_busy;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic              tx_end;
   logic              err;

   modport master (
      output req, req_data, tx_busy, tx_end,
      input  ack, grant_id, arb_busy, tx_start, tx_data, err
   );

   modport slave (
      input  req, req_data, tx_busy, tx_end,
      output ack, grant_id, arb_busy, tx_start, tx_data, err
   );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte sources (NREQ 2..8).
// Define UART_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles with a sticky err flag.
module uart_tx_arb #(
   parameter int unsigned NREQ    = 4,
   parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
   input logic          clk,
   input logic          reset,
   uart_tx_arb_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [2:0]      grant_q, grant_d;
   logic [2:0]      rr_q, rr_d, rr_next;
   logic            start_q, start_d;
   logic [7:0]      data_q, data_d;
   logic            busy_q;

   logic            found;
   logic [2:0]      win;
   logic [7:0]      win_data;
   logic [3:0]      idx;
   logic [NREQ-1:0] req_rot;
   logic [3:0]      gnext;

`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0]     cnt_q, cnt_d;
   logic            err_q, err_d;
`else
   logic            unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   // First set request at or after rr_q, wrapping modulo NREQ
   always_comb begin
      found   = 1'b0;
      win     = '0;
      idx     = '0;
      req_rot = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 4'(rr_q) + 4'(i);
         if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
         req_rot = bus.req >> idx;
         if (!found && req_rot[0]) begin
            found = 1'b1;
            win   = idx[2:0];
         end
      end
   end

   assign win_data = 8'(bus.req_data >> {win, 3'b000});
   assign gnext    = 4'(grant_q) + 4'd1;
   assign rr_next  = (gnext == 4'(NREQ)) ? 3'd0 : gnext[2:0];

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      ack_d   = '0;
      grant_d = grant_q;
      rr_d    = rr_q;
      start_d = 1'b0;
      data_d  = data_q;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (found && !bus.tx_busy) begin
               grant_d = win;
               data_d  = win_data;
               start_d = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            state_d = S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (bus.tx_end) begin
               ack_d   = NREQ'(1) << grant_q;
               rr_d    = rr_next;
               state_d = S_DONE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            // tx_end takes priority over an expiring count in the same cycle
            else if (cnt_q + 16'd1 == TIMEOUT) begin
               err_d   = 1'b1;
               ack_d   = NREQ'(1) << grant_q;
               rr_d    = rr_next;
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + 16'd1;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ack_q   <= '0;
         grant_q <= '0;
         rr_q    <= '0;
         start_q <= 1'b0;
         data_q  <= 8'h00;
         busy_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         start_q <= start_d;
         data_q  <= data_d;
         busy_q  <= (state_d != S_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign bus.ack      = ack_q;
   assign bus.grant_id = grant_q;
   assign bus.arb_busy = busy_q;
   assign bus.tx_start = start_q;
   assign bus.tx_data  = data_q;
`ifdef UART_ARB_TIMEOUT_EN
   assign bus.err      = err_q;
`else
   assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a behavioural uart_tx and a grant/ack scoreboard.
// The timeout steps run only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arb;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned FRAME = 20;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] id;
   } exp_t;

   logic clk          = 1'b0;
   logic reset        = 1'b1;
   logic force_busy   = 1'b0;
   logic suppress_end = 1'b0;
   logic inject_end   = 1'b0;
   logic       m_busy;
   logic       m_end;
   logic [7:0] m_cnt;

   int   errors  = 0;
   int   checks  = 0;
   int   n_ack   = 0;
   int   n_start = 0;
   logic ack_seen    = 1'b0;
   logic prev_start  = 1'b0;
   logic end_in_wait = 1'b0;

   exp_t            exp_q[$];
   logic [NREQ-1:0] ack_q[$];

   uart_tx_arb_if #(.NREQ(NREQ)) bus();

   uart_tx_arb #(.NREQ(NREQ), .TIMEOUT(16'd100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.tx_busy = m_busy | force_busy;
   assign bus.tx_end  = m_end | inject_end;

   // Behavioural uart_tx: busy for FRAME cycles after tx_start, then a one-cycle tx_end
   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_cnt  <= '0;
         m_end  <= 1'b0;
      end else begin
         m_end <= 1'b0;
         if (bus.tx_start && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= 8'(FRAME - 1);
         end else if (m_busy) begin
            if (m_cnt == 8'd0) begin
               m_busy <= 1'b0;
               m_end  <= !suppress_end;
            end else begin
               m_cnt <= m_cnt - 8'd1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and score whatever the DUT produced
   task automatic tick();
      exp_t            e;
      logic [NREQ-1:0] ea;
      @(negedge clk);
      ack_seen = 1'b0;
      if (end_in_wait) check("ack_latency", 32'(bus.ack != '0), 32'd1);
      if (bus.tx_start) begin
         n_start++;
         check("start_pulse", 32'(prev_start), 32'd0);
         check("start_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(e.data));
            check("grant_id", 32'(bus.grant_id), 32'(e.id));
         end
      end
      if (bus.ack != '0) begin
         n_ack++;
         ack_seen = 1'b1;
         check("ack_expected", 32'(ack_q.size() != 0), 32'd1);
         if (ack_q.size() != 0) begin
            ea = ack_q.pop_front();
            check("ack", 32'(bus.ack), 32'(ea));
         end
      end
      prev_start  = bus.tx_start;
      end_in_wait = bus.tx_end && bus.arb_busy && !bus.tx_start && (bus.ack == '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_ack(input int max_cyc);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while (!ack_seen && k < max_cyc);
      check("ack_wait", 32'(ack_seen), 32'd1);
   endtask

   task automatic expect_grant(input logic [7:0] data, input logic [2:0] id, input logic with_ack);
      exp_t e;
      e.data = data;
      e.id   = id;
      exp_q.push_back(e);
      if (with_ack) ack_q.push_back(NREQ'(1) << id);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ack"},      32'(bus.ack),      32'd0);
      check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
      check({tag, "_arb_busy"}, 32'(bus.arb_busy), 32'd0);
      check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
      check({tag, "_tx_data"},  32'(bus.tx_data),  32'h00);
      check({tag, "_err"},      32'(bus.err),      32'd0);
   endtask

   initial begin
      int a0;
      int s0;
      int k;
      bus.req      = '0;
      bus.req_data = '0;

      // Power-on reset for two cycles
      tick();
      tick();
      check_reset_values("por");
      reset = 1'b0;
      idle(2);

      // Round-robin: all sources request continuously; expect 0,1,2,3,0
      bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int i = 0; i < 5; i++) expect_grant(8'(8'h10 + i % 4), 3'(i % 4), 1'b1);
      bus.req = 4'hF;
      for (int i = 0; i < 5; i++) wait_ack(100);
      bus.req = '0;
      idle(3);

      // Single source 2 with 8'h3C
      bus.req_data = {8'h00, 8'h3C, 8'h00, 8'h00};
      expect_grant(8'h3C, 3'd2, 1'b1);
      bus.req = 4'b0100;
      tick();
      check("single_start_latency", 32'(bus.tx_start), 32'd1);
      wait_ack(100);
      bus.req = '0;
      check("single_grant_id", 32'(bus.grant_id), 32'd2);
      idle(3);

      // Busy hold-off: no grant while tx_busy is high
      force_busy   = 1'b1;
      bus.req_data = {8'h00, 8'h00, 8'h00, 8'h5E};
      expect_grant(8'h5E, 3'd0, 1'b1);
      bus.req = 4'b0001;
      s0 = n_start;
      idle(6);
      check("holdoff_no_start", 32'(n_start - s0), 32'd0);
      check("holdoff_idle", 32'(bus.arb_busy), 32'd0);
      force_busy = 1'b0;
      tick();
      check("holdoff_release", 32'(bus.tx_start), 32'd1);
      wait_ack(100);
      bus.req = '0;
      idle(3);

      // Dropped request: source 1 lets go during WAIT, ack still pulses once
      bus.req_data = {8'h00, 8'h00, 8'hC3, 8'h00};
      expect_grant(8'hC3, 3'd1, 1'b1);
      bus.req = 4'b0010;
      tick();
      idle(3);
      bus.req = '0;
      a0 = n_ack;
      wait_ack(100);
      idle(4);
      check("drop_one_ack", 32'(n_ack - a0), 32'd1);

      // Stray tx_end while idle is ignored
      a0 = n_ack;
      s0 = n_start;
      inject_end = 1'b1;
      tick();
      inject_end = 1'b0;
      idle(4);
      check("stray_no_ack", 32'(n_ack - a0), 32'd0);
      check("stray_no_start", 32'(n_start - s0), 32'd0);
      check("stray_idle", 32'(bus.arb_busy), 32'd0);

      // Reset mid-WAIT aborts the frame without an ack
      bus.req_data = {8'h77, 8'h00, 8'h00, 8'h00};
      expect_grant(8'h77, 3'd3, 1'b0);
      bus.req = 4'b1000;
      tick();
      idle(3);
      check("in_wait_busy", 32'(bus.arb_busy), 32'd1);
      a0 = n_ack;
      reset = 1'b1;
      tick();
      tick();
      bus.req = '0;
      check_reset_values("midrst");
      reset = 1'b0;
      idle(3);
      check("midrst_no_ack", 32'(n_ack - a0), 32'd0);
      bus.req_data = {8'h00, 8'h00, 8'hA5, 8'h00};
      expect_grant(8'hA5, 3'd1, 1'b1);
      bus.req = 4'b0010;
      tick();
      check("post_reset_start", 32'(bus.tx_start), 32'd1);
      wait_ack(100);
      bus.req = '0;
      idle(3);

`ifdef UART_ARB_TIMEOUT_EN
      // Timeout: tx_end suppressed, abort after 100 WAIT cycles
      suppress_end = 1'b1;
      bus.req_data = {8'h5A, 8'h00, 8'h00, 8'h00};
      expect_grant(8'h5A, 3'd3, 1'b1);
      bus.req = 4'b1000;
      tick();
      check("to_start", 32'(bus.tx_start), 32'd1);
      k = 0;
      do begin
         tick();
         k++;
      end while (!ack_seen && k < 300);
      check("to_ack_cycle", 32'(k), 32'd101);
      check("to_err_set", 32'(bus.err), 32'd1);
      bus.req      = '0;
      suppress_end = 1'b0;
      idle(3);
      bus.req_data = {8'h00, 8'h00, 8'h00, 8'h01};
      expect_grant(8'h01, 3'd0, 1'b1);
      bus.req = 4'b0001;
      wait_ack(100);
      bus.req = '0;
      check("to_err_sticky", 32'(bus.err), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("to_err_cleared", 32'(bus.err), 32'd0);
      idle(2);
`else
      check("err_tied_low", 32'(bus.err), 32'd0);
`endif

      check("scoreboard_starts_drained", 32'(exp_q.size()), 32'd0);
      check("scoreboard_acks_drained", 32'(ack_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
